// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / hazard controller:
// forward-select encodings and the RUN/STALL state type.
package fwd_pkg;

    // Operand source selects driven to the EXE stage (2'b11 is never produced)
    localparam logic [1:0] SEL_REG = 2'b00;  // register file
    localparam logic [1:0] SEL_MEM = 2'b01;  // MEM-stage ALU result
    localparam logic [1:0] SEL_WB  = 2'b10;  // WB-stage result

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand dependency check: compares one ID source register against the
// EXE and MEM destinations and produces this operand's forward select and its
// contribution to the pipeline hazard.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic             en_forwarding,
    input  logic [REG_W-1:0] src,
    input  logic             src_vld,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] exe_dst,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dst,
    output logic             hazard,
    output logic [1:0]       next_sel
);

    logic hit_exe;
    logic hit_mem;

    assign hit_exe = src_vld & exe_wb_en & (exe_dst == src);
    assign hit_mem = src_vld & mem_wb_en & (mem_dst == src);

    // Select a bypass source (EXE producer wins) or flag a hazard for this operand
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_sel = SEL_REG;
        hazard   = 1'b0;
        if (en_forwarding) begin
            // A load in EXE has no data yet: that is the only case forwarding cannot cover
            hazard = hit_exe & exe_mem_r_en;
            if (hit_exe && !exe_mem_r_en) begin
                next_sel = SEL_MEM;
            end else if (hit_mem) begin
                next_sel = SEL_WB;
            end
        end else begin
            hazard = hit_exe | hit_mem;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage pipeline. Decides in ID
// whether each source operand is bypassed or the pipeline must stall, and
// registers the selects for use in EXE one cycle later.
// Optional statistics counters are built when FWD_HAZARD_STATS_EN is defined;
// otherwise stall_cnt / fwd_cnt read constant zero.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int REG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_forwarding,
    input  logic                     flush,
    input  logic [NUM_SRC*REG_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]       id_src_vld,
    input  logic                     exe_wb_en,
    input  logic                     exe_mem_r_en,
    input  logic [REG_W-1:0]         exe_dst,
    input  logic                     mem_wb_en,
    input  logic [REG_W-1:0]         mem_dst,
    output logic                     stall,
    output logic [2*NUM_SRC-1:0]     ex_sel,
    output logic                     ex_fwd_any,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         fwd_cnt
);

    logic [NUM_SRC-1:0]   src_hazard;
    logic [2*NUM_SRC-1:0] next_sel;
    logic                 hazard;
    logic [2*NUM_SRC-1:0] ex_sel_d, ex_sel_q;
    state_e               state_d, state_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(.REG_W(REG_W)) u_match (
            .en_forwarding (en_forwarding),
            .src           (id_src[i*REG_W +: REG_W]),
            .src_vld       (id_src_vld[i]),
            .exe_wb_en     (exe_wb_en),
            .exe_mem_r_en  (exe_mem_r_en),
            .exe_dst       (exe_dst),
            .mem_wb_en     (mem_wb_en),
            .mem_dst       (mem_dst),
            .hazard        (src_hazard[i]),
            .next_sel      (next_sel[2*i +: 2])
        );
    end

    // A flushed ID instruction is dead, and reset must never report a stall
    assign hazard     = |src_hazard;
    assign stall      = hazard & ~flush & ~rst;
    assign ex_sel     = ex_sel_q;
    assign ex_fwd_any = |ex_sel_q;

    // Next EXE selects (bubble on stall/flush) and RUN/STALL next state
    always_comb begin
        ex_sel_d = next_sel;
        state_d  = state_q;
        if (stall || flush) begin
            ex_sel_d = '0;
        end
        case (state_q)
            RUN:     if (stall)  state_d = STALL;
            STALL:   if (!stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Pipeline select register and FSM state
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            ex_sel_q <= '0;
            state_q  <= RUN;
        end else begin
            ex_sel_q <= ex_sel_d;
            state_q  <= state_d;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d, fwd_cnt_q;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (ex_fwd_any && (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
// Counter expectations follow FWD_HAZARD_STATS_EN.
module tb_fwd_hazard_ctrl;
    import fwd_pkg::*;

    localparam int NUM_SRC = 3;
    localparam int REG_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef FWD_HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en_forwarding;
    logic                     flush;
    logic [NUM_SRC*REG_W-1:0] id_src;
    logic [NUM_SRC-1:0]       id_src_vld;
    logic                     exe_wb_en;
    logic                     exe_mem_r_en;
    logic [REG_W-1:0]         exe_dst;
    logic                     mem_wb_en;
    logic [REG_W-1:0]         mem_dst;
    logic                     stall;
    logic [2*NUM_SRC-1:0]     ex_sel;
    logic                     ex_fwd_any;
    logic [CNT_W-1:0]         stall_cnt;
    logic [CNT_W-1:0]         fwd_cnt;

    fwd_hazard_ctrl #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_forwarding (en_forwarding),
        .flush         (flush),
        .id_src        (id_src),
        .id_src_vld    (id_src_vld),
        .exe_wb_en     (exe_wb_en),
        .exe_mem_r_en  (exe_mem_r_en),
        .exe_dst       (exe_dst),
        .mem_wb_en     (mem_wb_en),
        .mem_dst       (mem_dst),
        .stall         (stall),
        .ex_sel        (ex_sel),
        .ex_fwd_any    (ex_fwd_any),
        .stall_cnt     (stall_cnt),
        .fwd_cnt       (fwd_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state (what the outputs should read after the last edge)
    int m_sel [NUM_SRC];
    int m_stall_cnt;
    int m_fwd_cnt;
    bit m_in_stall;
    logic obs_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Where operand i should be read from next cycle, straight from the rules
    function automatic int model_sel(int i);
        int  src = int'(id_src[i*REG_W +: REG_W]);
        bit  he  = id_src_vld[i] && exe_wb_en && (int'(exe_dst) == src);
        bit  hm  = id_src_vld[i] && mem_wb_en && (int'(mem_dst) == src);
        if (!en_forwarding)        return 0;
        if (he && !exe_mem_r_en)   return 1;
        if (hm)                    return 2;
        return 0;
    endfunction

    function automatic bit model_hazard();
        for (int i = 0; i < NUM_SRC; i++) begin
            int src = int'(id_src[i*REG_W +: REG_W]);
            bit he  = id_src_vld[i] && exe_wb_en && (int'(exe_dst) == src);
            bit hm  = id_src_vld[i] && mem_wb_en && (int'(mem_dst) == src);
            if (en_forwarding  && he && exe_mem_r_en) return 1'b1;
            if (!en_forwarding && (he || hm))         return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2*NUM_SRC-1:0] model_sel_vec();
        logic [2*NUM_SRC-1:0] v = '0;
        for (int i = 0; i < NUM_SRC; i++) v[2*i +: 2] = 2'(m_sel[i]);
        return v;
    endfunction

    // One clock: check combinational stall, advance the model, check registered outputs
    task automatic step(input string tag);
        bit exp_stall;
        bit cur_any;
        #1;
        exp_stall = !rst && !flush && model_hazard();
        obs_stall = stall;
        check({tag, "/stall"}, 32'(stall), 32'(exp_stall));
        cur_any = (model_sel_vec() != '0);
        if (rst) begin
            for (int i = 0; i < NUM_SRC; i++) m_sel[i] = 0;
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
            m_in_stall  = 1'b0;
        end else begin
            if (STATS && exp_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (STATS && cur_any   && m_fwd_cnt   < CNT_MAX) m_fwd_cnt++;
            for (int i = 0; i < NUM_SRC; i++) m_sel[i] = (exp_stall || flush) ? 0 : model_sel(i);
            m_in_stall = exp_stall;
        end
        @(posedge clk);
        #1;
        check({tag, "/ex_sel"},     32'(ex_sel),       32'(model_sel_vec()));
        check({tag, "/fwd_any"},    32'(ex_fwd_any),   32'(model_sel_vec() != '0));
        check({tag, "/stall_cnt"},  32'(stall_cnt),    32'(m_stall_cnt));
        check({tag, "/fwd_cnt"},    32'(fwd_cnt),      32'(m_fwd_cnt));
        check({tag, "/state"},      32'(dut.state_q),  32'(m_in_stall ? STALL : RUN));
    endtask

    task automatic idle();
        flush        = 1'b0;
        id_src       = '0;
        id_src_vld   = '0;
        exe_wb_en    = 1'b0;
        exe_mem_r_en = 1'b0;
        exe_dst      = '0;
        mem_wb_en    = 1'b0;
        mem_dst      = '0;
    endtask

    task automatic set_src(input int i, input logic [REG_W-1:0] r);
        id_src[i*REG_W +: REG_W] = r;
        id_src_vld[i]            = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        en_forwarding = 1'b1;
        idle();
        step("reset0");
        step("reset1");
        check("reset/ex_sel_zero", 32'(ex_sel), 32'h0);
        rst = 1'b0;

        // ALU result in EXE forwarded from MEM next cycle
        idle();
        exe_wb_en = 1'b1; exe_dst = 4'd3; set_src(0, 4'd3);
        step("alu_fwd");
        check("alu_fwd/no_stall", 32'(obs_stall), 32'h0);
        check("alu_fwd/sel0", 32'(ex_sel[1:0]), 32'(SEL_MEM));

        // Load-use: one stall with bubble, then forward from WB
        idle();
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dst = 4'd5; set_src(1, 4'd5);
        step("load_use");
        check("load_use/stall", 32'(obs_stall), 32'h1);
        check("load_use/bubble", 32'(ex_sel), 32'h0);
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b1; mem_dst = 4'd5;
        step("load_wb");
        check("load_wb/no_stall", 32'(obs_stall), 32'h0);
        check("load_wb/sel1", 32'(ex_sel[3:2]), 32'(SEL_WB));
        check("load_wb/stall_cnt", 32'(stall_cnt), STATS ? 32'h1 : 32'h0);

        // Stall-only mode: a MEM producer stalls, no selects
        idle();
        en_forwarding = 1'b0; mem_wb_en = 1'b1; mem_dst = 4'd7; set_src(2, 4'd7);
        step("stall_only");
        check("stall_only/stall", 32'(obs_stall), 32'h1);
        check("stall_only/sel", 32'(ex_sel), 32'h0);
        id_src_vld[2] = 1'b0;
        step("stall_only_novld");
        check("stall_only_novld/stall", 32'(obs_stall), 32'h0);

        // EXE producer has priority over MEM producer
        idle();
        en_forwarding = 1'b1;
        exe_wb_en = 1'b1; exe_dst = 4'd4; mem_wb_en = 1'b1; mem_dst = 4'd4; set_src(0, 4'd4);
        step("exe_prio");
        check("exe_prio/sel0", 32'(ex_sel[1:0]), 32'(SEL_MEM));

        // Flush beats load-use hazard; reset in the middle of a stall
        idle();
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_dst = 4'd5; set_src(1, 4'd5); flush = 1'b1;
        step("flush_haz");
        check("flush_haz/stall", 32'(obs_stall), 32'h0);
        check("flush_haz/sel", 32'(ex_sel), 32'h0);
        flush = 1'b0;
        step("stall_before_rst");
        check("stall_before_rst/state", 32'(dut.state_q), 32'(STALL));
        rst = 1'b1;
        step("rst_mid_stall");
        check("rst_mid_stall/stall", 32'(obs_stall), 32'h0);
        check("rst_mid_stall/stall_cnt", 32'(stall_cnt), 32'h0);
        check("rst_mid_stall/fwd_cnt", 32'(fwd_cnt), 32'h0);
        rst = 1'b0;

        // Sustained load-use: stall counter saturates
        for (int k = 0; k < 21; k++) step("sat");
        check("sat/stall_cnt", 32'(stall_cnt), STATS ? 32'(CNT_MAX) : 32'h0);

        // Randomized traffic with a small register space to provoke hits
        for (int k = 0; k < 400; k++) begin
            rst           = ($urandom_range(0, 39) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            en_forwarding = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_SRC; i++) id_src[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 3));
            id_src_vld    = NUM_SRC'($urandom);
            exe_wb_en     = 1'($urandom);
            exe_mem_r_en  = 1'($urandom);
            exe_dst       = REG_W'($urandom_range(0, 3));
            mem_wb_en     = 1'($urandom);
            mem_dst       = REG_W'($urandom_range(0, 3));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
